// File: rtl/fdc_pkg.sv
// fdc_pkg: FSM states and accumulator sizing shared by the FDC sequencer.
package fdc_pkg;
   typedef enum logic [1:0] {IDLE, HOLD, WAIT, OUT} state_t;
   localparam int ACC_W_DEFAULT = 5 + 2;
   function automatic int acc_width(input int ptat_n, input int avg_log2);
      return ptat_n + avg_log2;
   endfunction
endpackage

// File: rtl/fdc_sync.sv
// fdc_sync: STAGES-deep single-bit synchronizer, cleared by reset.
module fdc_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] ff;
   always_ff @(posedge clk or posedge reset)
      if (reset) ff <= '0;
      else ff <= STAGES'({ff, d});
   assign q = ff[STAGES-1];
endmodule

// File: rtl/fdc_controller.sv
// fdc_controller: sequences FDC conversions, averages 2^AVG_LOG2 samples and
// hands the result out over valid/ready with timeout and saturation flags.
module fdc_controller
   import fdc_pkg::*;
#(
   parameter int PTAT_N         = 5,
   parameter int AVG_LOG2       = 2,
   parameter int RST_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int SYNC_STAGES    = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              continuous,
   input  logic              fdc_done,
   input  logic [PTAT_N-1:0] fdc_data,
   output logic              fdc_reset,
   output logic              busy,
   output logic [PTAT_N-1:0] result,
   output logic              result_valid,
   input  logic              result_ready,
   output logic              timeout,
   output logic              saturated
);
   localparam int ACC_W  = acc_width(PTAT_N, AVG_LOG2);
   localparam int CNT_W  = $clog2(RST_CYCLES > TIMEOUT_CYCLES ? RST_CYCLES : TIMEOUT_CYCLES) + 1;
   localparam int SCNT_W = AVG_LOG2 + 1;
   state_t state, next;
   logic done_s, sample, expired, hold_done, last, hs;
   logic [CNT_W-1:0] cnt;
   logic [SCNT_W-1:0] scnt;
   logic [ACC_W-1:0] acc, acc_sum;
   fdc_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk(clk),
      .reset(reset),
      .d(fdc_done),
      .q(done_s)
   );
   assign sample    = state == WAIT && done_s;
   assign expired   = state == WAIT && !done_s && cnt == CNT_W'(TIMEOUT_CYCLES - 1);
   assign hold_done = cnt == CNT_W'(RST_CYCLES - 1);
   assign last      = scnt == SCNT_W'((1 << AVG_LOG2) - 1);
   assign hs        = state == OUT && result_ready;
   assign acc_sum   = acc + ACC_W'(fdc_data);
   always_comb begin
      next = state;
      case (state)
         IDLE:    next = start ? HOLD : IDLE;
         HOLD:    next = hold_done ? WAIT : HOLD;
         WAIT:    next = sample ? (last ? OUT : HOLD) : (expired ? OUT : WAIT);
         OUT:     next = result_ready ? (continuous ? HOLD : IDLE) : OUT;
         default: next = IDLE;
      endcase
   end
   // Outputs are registered from the next state so fdc_reset is a clean flop output.
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         scnt         <= '0;
         acc          <= '0;
         fdc_reset    <= 1'b1;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         result       <= '0;
         timeout      <= 1'b0;
         saturated    <= 1'b0;
      end else begin
         state        <= next;
         cnt          <= next != state ? '0 : cnt + 1'b1;
         fdc_reset    <= next != WAIT;
         busy         <= next != IDLE;
         result_valid <= next == OUT;
         if (state == IDLE || hs) begin
            acc       <= '0;
            scnt      <= '0;
            timeout   <= 1'b0;
            saturated <= 1'b0;
         end else if (sample) begin
            acc  <= acc_sum;
            scnt <= scnt + 1'b1;
            if (&fdc_data) saturated <= 1'b1;
            if (last) result <= acc_sum[ACC_W-1:AVG_LOG2];
         end else if (expired) begin
            timeout <= 1'b1;
            result  <= '0;
         end
      end
endmodule

// File: tb/tb_fdc_controller.sv
// tb_fdc_controller: randomized FDC model plus scoreboard of expected averages.
module tb_fdc_controller;
   typedef struct {int res; bit to; bit sat;} exp_t;
   logic clk = 1'b0, reset = 1'b1, start = 1'b0, continuous = 1'b0;
   logic fdc_done = 1'b0, result_ready = 1'b1;
   logic [4:0] fdc_data = '0, result;
   logic fdc_reset, busy, result_valid, timeout, saturated;
   int tests = 0, fails = 0, falls = 0, timer = 0, cur_delay = 1, fixed_delay = 0;
   int idle_seen = 0, h_res = 0, h_flags = 0;
   bit held = 0, in_cont = 0;
   int fdc_q[$];
   exp_t exp_q[$];

   fdc_controller #(
      .PTAT_N(5), .AVG_LOG2(2), .RST_CYCLES(4), .TIMEOUT_CYCLES(64), .SYNC_STAGES(2)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .continuous(continuous),
      .fdc_done(fdc_done), .fdc_data(fdc_data), .fdc_reset(fdc_reset), .busy(busy),
      .result(result), .result_valid(result_valid), .result_ready(result_ready),
      .timeout(timeout), .saturated(saturated)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // FDC model: done rises a random number of cycles after release, with sub-cycle jitter.
   always @(negedge fdc_reset) begin
      falls++;
      cur_delay = fixed_delay != 0 ? fixed_delay : int'($urandom_range(1, 20));
   end
   always @(posedge fdc_reset) begin
      fdc_done = 1'b0;
      fdc_data = '0;
   end
   always @(posedge clk or posedge fdc_reset)
      if (fdc_reset) timer <= 0;
      else timer <= timer + 1;
   always @(posedge clk)
      if (!fdc_reset && !fdc_done && timer == cur_delay && fdc_q.size() > 0) begin
         #($urandom_range(1, 4));
         if (!fdc_reset) begin
            fdc_data = 5'(fdc_q.pop_front());
            fdc_done = 1'b1;
         end
      end

   // Monitor: compares on each handshake and checks the result holds under backpressure.
   always @(negedge clk) begin
      if (reset) held = 0;
      else begin
         if (held) begin
            check("hold_valid", result_valid, 1);
            check("hold_result", result, h_res);
            check("hold_flags", {timeout, saturated}, h_flags);
         end
         held = 0;
         if (result_valid) begin
            check("out_fdc_reset", fdc_reset, 1);
            if (result_ready) begin
               if (exp_q.size() == 0) check("unexpected_result", result_valid, 0);
               else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  check("result", result, e.res);
                  check("timeout", timeout, e.to);
                  check("saturated", saturated, e.sat);
               end
            end else begin
               held = 1;
               h_res = result;
               h_flags = {timeout, saturated};
            end
         end
         if (in_cont && !busy) idle_seen++;
      end
   end

   task automatic push_result(input int n, input int a, input int b, input int c, input int d);
      int s[4];
      exp_t e;
      s = '{a, b, c, d};
      e.res = 0;
      e.to = n == 0;
      e.sat = 0;
      for (int i = 0; i < n; i++) begin
         fdc_q.push_back(s[i]);
         e.res += s[i];
         if (s[i] == 31) e.sat = 1;
      end
      e.res = e.res / 4;
      exp_q.push_back(e);
   endtask

   task automatic run(input int n, input int a, input int b, input int c, input int d, input int bp);
      int k;
      push_result(n, a, b, c, d);
      falls = 0;
      result_ready = bp == 0;
      @(posedge clk); #1 start = 1;
      @(posedge clk); #1 start = 0;
      check("busy_rise", busy, 1);
      k = 0;
      while (fdc_reset && k < 20) begin @(posedge clk); #1; k++; end
      check("release_latency", k, 4);
      k = 0;
      while (!result_valid && k < 3000) begin @(posedge clk); #1; k++; end
      check("valid_in_time", result_valid, 1);
      repeat (bp) @(posedge clk);
      #1 result_ready = 1;
      k = 0;
      while (exp_q.size() != 0 && k < 100) begin @(posedge clk); k++; end
      check("handshake", exp_q.size(), 0);
      @(negedge clk);
      check("busy_fall", busy, 0);
      check("valid_fall", result_valid, 0);
      check("release_count", falls, n == 0 ? 1 : n);
   endtask

   initial begin
      int k;
      repeat (3) @(posedge clk);
      #1;
      check("rst_fdc_reset", fdc_reset, 1);
      check("rst_busy", busy, 0);
      check("rst_valid", result_valid, 0);
      check("rst_result", result, 0);
      check("rst_flags", {timeout, saturated}, 0);
      @(negedge clk) reset = 0;

      run(4, 10, 11, 12, 13, 0);
      run(4, 31, 31, 31, 31, 0);
      run(4, 31, 0, 0, 0, 0);
      run(0, 0, 0, 0, 0, 0);
      run(4, 5, 9, 17, 30, 20);
      for (int i = 0; i < 8; i++)
         run(4, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             ($urandom_range(0, 3) == 0) ? 31 : $urandom_range(0, 31),
             ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0);

      // continuous back-to-back results
      push_result(4, 8, 8, 8, 8);
      push_result(4, 4, 4, 4, 4);
      push_result(4, 0, 0, 0, 4);
      falls = 0;
      idle_seen = 0;
      continuous = 1;
      @(posedge clk); #1 start = 1;
      @(posedge clk); #1 start = 0;
      in_cont = 1;
      k = 0;
      while (exp_q.size() > 1 && k < 3000) begin @(posedge clk); k++; end
      #1 continuous = 0;
      k = 0;
      while (exp_q.size() != 0 && k < 3000) begin @(posedge clk); k++; end
      in_cont = 0;
      check("cont_drained", exp_q.size(), 0);
      check("cont_idle_cycles", idle_seen, 0);
      check("cont_release_count", falls, 12);
      @(negedge clk);
      check("cont_busy_fall", busy, 0);

      // reset during the second conversion's WAIT
      fixed_delay = 30;
      fdc_q.push_back(20);
      @(posedge clk); #1 start = 1;
      @(posedge clk); #1 start = 0;
      k = 0;
      while (fdc_q.size() != 0 && k < 200) begin @(posedge clk); k++; end
      while (!fdc_reset && k < 400) begin @(posedge clk); k++; end
      while (fdc_reset && k < 400) begin @(posedge clk); k++; end
      check("second_release", fdc_reset, 0);
      repeat (2) @(posedge clk);
      #2 reset = 1;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_fdc_reset", fdc_reset, 1);
      check("midrst_valid", result_valid, 0);
      @(negedge clk) reset = 0;
      fixed_delay = 0;
      run(4, 1, 2, 3, 4, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
      $fatal(1);
   end
endmodule

// File: doc/fdc_controller.md
# fdc_controller

Synchronous sequencer for the asynchronous ripple-counter frequency-to-digital converter (FDC). It holds the FDC in reset while idle, releases it to run a conversion, and detects the FDC's asynchronous `done` through a synchronizer. It then captures the conversion word and averages 2^AVG_LOG2 conversions. The averaged result goes to the system through a valid/ready handshake, with timeout and saturation flags.

## Interface
Parameters:
- PTAT_N, 5, width of the FDC conversion word.
- AVG_LOG2, 2, log2 of conversions averaged per result (0 = single conversion).
- RST_CYCLES, 4, cycles `fdc_reset` is held before each conversion; must be ≥ SYNC_STAGES+1.
- TIMEOUT_CYCLES, 4096, maximum cycles waiting for `done` per conversion.
- SYNC_STAGES, 2, flip-flop stages on `fdc_done`.

Ports:
- clk  in  1  system clock; everything below is in this domain except `fdc_done`.
- reset  in  1  asynchronous, active-high.
- start  in  1  request one result; sampled only in IDLE.
- continuous  in  1  if 1 at handshake, start the next result immediately.
- fdc_done  in  1  FDC done, asynchronous to clk.
- fdc_data  in  PTAT_N  FDC registered count; stable while `fdc_done`=1.
- fdc_reset  out  1  FDC reset; 1 holds counters and register cleared.
- busy  out  1  1 in every state except IDLE.
- result  out  PTAT_N  floor(sum of samples / 2^AVG_LOG2).
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts the result.
- timeout  out  1  qualifies `result`: a conversion timed out.
- saturated  out  1  qualifies `result`: at least one sample equalled all-ones.

## Operation
- FSM states: IDLE, HOLD, WAIT, OUT.
- IDLE:
  - `fdc_reset`=1, sample count cleared, accumulator cleared.
  - `start`=1 → HOLD.
- HOLD:
  - `fdc_reset`=1 for exactly RST_CYCLES cycles, then → WAIT.
  - RST_CYCLES ≥ SYNC_STAGES+1 guarantees the synchronized done (`done_s`) is 0 on WAIT entry.
- WAIT:
  - `fdc_reset`=0, timeout counter runs.
  - On the first cycle `done_s`=1:
    - acc += fdc_data, zero-extended to PTAT_N+AVG_LOG2 bits.
    - fdc_data == all-ones sets the sticky sat flag.
    - Increment the sample count.
    - If count reaches 2^AVG_LOG2 → OUT, else → HOLD.
  - The accumulate must happen before HOLD, because the FDC reset also clears the FDC data register.
  - Timeout counter reaches TIMEOUT_CYCLES-1 without `done_s`: set the timeout flag, result forced to 0, → OUT.
- OUT:
  - `result_valid`=1, `fdc_reset`=1.
  - `result` = acc[PTAT_N+AVG_LOG2-1:AVG_LOG2]; the accumulator cannot overflow by construction.
  - `result`, `timeout`, `saturated` are held stable until the handshake.
  - Handshake (`result_valid`&`result_ready`):
    - If `continuous`=1 → HOLD with accumulator, count and flags cleared.
    - Else → IDLE.
- Reset mid-operation returns to IDLE within the asynchronous assertion. The FDC is forced back into reset, which invalidates any in-flight conversion.

## Timing
- Reset values:
  - `fdc_reset`=1; `busy`, `result_valid`, `timeout`, `saturated` = 0; `result`=0.
  - All synchronizer stages = 0.
- All outputs are registered; `fdc_reset` must be glitch-free (direct flop output).
- `start`=1 in IDLE at cycle t: `busy`=1 and HOLD at t+1; `fdc_reset` falls at t+1+RST_CYCLES.
- `done_s` lags `fdc_done` by SYNC_STAGES cycles. `fdc_data` is sampled only after `done_s`=1, so it has been stable for ≥ SYNC_STAGES-1 cycles.
- Latency per result = 1 + 2^AVG_LOG2 × (RST_CYCLES + conversion time + SYNC_STAGES) + 1 cycles to `result_valid`.
- `result_ready` may be held high in advance; the handshake completes on the first OUT cycle.
- `start` while busy is ignored, with no queuing.
- `continuous` is sampled only at the handshake.

## Structure
- Shared package `fdc_pkg`: FSM state enum and a localparam for the accumulator width PTAT_N+AVG_LOG2.
- Sub-module `fdc_sync`: SYNC_STAGES-deep 1-bit synchronizer, reset to 0.
- The controller instantiates `fdc_sync` on `fdc_done`; the FSM, counters and accumulator live in the top.

## Test plan
FDC behavioural model: `fdc_done` rises D cycles after `fdc_reset` falls, with programmable `fdc_data`; asynchronous jitter on `fdc_done` edges. Default parameters unless stated.
- Single result, AVG_LOG2=2, samples 10, 11, 12, 13 → `result`=11, `timeout`=0, `saturated`=0; exactly 4 `fdc_reset` falling edges; `busy` falls one cycle after the handshake.
- AVG_LOG2=0, sample 31 → `result`=31, `saturated`=1.
- Model never asserts done, TIMEOUT_CYCLES=64 → `result_valid` with `timeout`=1 and `result`=0, first conversion only; `fdc_reset`=1 during OUT.
- Backpressure: `result_ready`=0 for 20 cycles → `result`, flags and `result_valid` unchanged; no new `fdc_reset` release until the handshake.
- `continuous`=1, three results of samples (8,8,8,8), (4,4,4,4), (0,0,0,4) → 8, 4, 1, with no IDLE cycle between results.
- `reset` asserted mid-WAIT on the second sample → immediate IDLE, `fdc_reset`=1, `busy`=0; the next `start` yields a correct fresh average with no leftover accumulator contribution.
